// File: rtl/mips_instr_assembler.sv
// Packs decoded MIPS fields into 32-bit words and streams them into instruction memory.
// Optional ASM_ADDI_EN adds class 5 (ADDI) to the set of legal encodings.
module mips_instr_assembler #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   acc_cnt;
    logic              legal;
    logic [31:0]       enc;
    logic              accept;
    logic              wr_new;
    logic              wr_done;

    always_comb begin
        legal = 1'b1;
        enc   = '0;
        case (in_cls)
            3'd0: enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, in_funct};
            3'd1: enc = {6'h23, in_rs, in_rt, in_imm};
            3'd2: enc = {6'h2B, in_rs, in_rt, in_imm};
            3'd3: enc = {6'h04, in_rs, in_rt, in_imm};
            3'd4: enc = {6'h02, in_target};
`ifdef ASM_ADDI_EN
            3'd5: enc = {6'h08, in_rs, in_rt, in_imm};
`endif
            default: legal = 1'b0;
        endcase
    end

    assign in_ready = (state == S_RUN) & (~mem_we | mem_ready);
    assign accept   = in_valid & in_ready;
    // acc_cnt MSB set means the memory is already full: drop the bundle
    assign wr_new   = accept & legal & ~acc_cnt[ADDR_W];
    assign wr_done  = mem_we & mem_ready;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            base       <= '0;
            acc_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            if (wr_done)
                word_count <= word_count + 1'b1;
            if (wr_new) begin
                mem_we    <= 1'b1;
                mem_addr  <= base + acc_cnt[ADDR_W-1:0];
                mem_wdata <= enc;
                acc_cnt   <= acc_cnt + 1'b1;
            end else if (wr_done) begin
                mem_we <= 1'b0;
            end
            if (accept && !wr_new)
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base       <= base_addr;
                        acc_cnt    <= '0;
                        word_count <= '0;
                        err        <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept && in_last)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (!mem_we || mem_ready)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_assembler.sv
// Directed bench for mips_instr_assembler: table of single-bundle sessions
// plus hand-written streaming, stall, error, wrap/overflow and reset sequences.
module tb_mips_instr_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic [2:0]  in_cls;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        mem_ready;

    logic        in_ready_a, mem_we_a, busy_a, done_a, err_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [8:0]  word_count_a;

    logic        in_ready_b, mem_we_b, busy_b, done_b, err_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  word_count_b;

    logic        sel;
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    mips_instr_assembler #(.ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_cls(in_cls),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ready(mem_ready), .busy(busy_a), .done(done_a), .err(err_a),
        .word_count(word_count_a)
    );

    mips_instr_assembler #(.ADDR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr[1:0]),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_cls(in_cls),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ready(mem_ready), .busy(busy_b), .done(done_b), .err(err_b),
        .word_count(word_count_b)
    );

    wire       s_ready = sel ? in_ready_b : in_ready_a;
    wire       s_busy  = sel ? busy_b : busy_a;
    wire       s_err   = sel ? err_b : err_a;
    wire [8:0] s_wc    = sel ? {6'd0, word_count_b} : word_count_a;

    always @(posedge clk) begin
        if (mem_we_a && mem_ready) begin
            wa_q.push_back(mem_addr_a);
            wd_q.push_back(mem_wdata_a);
        end
        if (mem_we_b && mem_ready) begin
            wa_q.push_back({6'd0, mem_addr_b});
            wd_q.push_back(mem_wdata_b);
        end
        if (done_a || done_b)
            done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tg;
        logic [7:0]  base;
        logic        exp_we;
        logic [31:0] exp_d;
        logic        exp_err;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b);
        base_addr = b;
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tg, input logic last);
        bit ok;
        ok        = 1'b0;
        in_cls    = c;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_funct  = fn;
        in_imm    = imm;
        in_target = tg;
        in_last   = last;
        in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (s_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready never rose");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!s_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy stuck high");
        end
    endtask

    int d0;

    initial begin
        tbl[0] = '{3'd0, 5'd8,  5'd9,  5'd10, 6'h20, 16'hAAAA, 26'h155, 8'h00, 1'b1, 32'h01095020, 1'b0};
        tbl[1] = '{3'd0, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h0,   8'h80, 1'b1, 32'h03FFF83F, 1'b0};
        tbl[2] = '{3'd1, 5'd16, 5'd9,  5'd5,  6'h3F, 16'h0004, 26'h3AB, 8'h10, 1'b1, 32'h8E090004, 1'b0};
        tbl[3] = '{3'd1, 5'd0,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,   8'hFF, 1'b1, 32'h8C00FFFF, 1'b0};
        tbl[4] = '{3'd2, 5'd16, 5'd9,  5'd1,  6'h01, 16'h0008, 26'h0,   8'h01, 1'b1, 32'hAE090008, 1'b0};
        tbl[5] = '{3'd3, 5'd8,  5'd9,  5'd0,  6'h00, 16'hFFFE, 26'h0,   8'h7F, 1'b1, 32'h1109FFFE, 1'b0};
        tbl[6] = '{3'd4, 5'd1,  5'd2,  5'd3,  6'h3F, 16'hFFFF, 26'h3FFFFFF, 8'h33, 1'b1, 32'h0BFFFFFF, 1'b0};
        tbl[7] = '{3'd6, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0001, 26'h1,   8'h44, 1'b0, 32'h0, 1'b1};
`ifdef ASM_ADDI_EN
        tbl[8] = '{3'd5, 5'd0,  5'd8,  5'd0,  6'h00, 16'h0005, 26'h0,   8'h55, 1'b1, 32'h20080005, 1'b0};
`else
        tbl[8] = '{3'd5, 5'd0,  5'd8,  5'd0,  6'h00, 16'h0005, 26'h0,   8'h55, 1'b0, 32'h0, 1'b1};
`endif

        sel = 1'b0; rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        base_addr = '0; in_valid = 1'b0; in_cls = '0; in_rs = '0;
        in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
        in_target = '0; in_last = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'({in_ready_a, mem_we_a, busy_a, done_a, err_a}), 64'd0);
        chk("rst_addr", 64'(mem_addr_a), 64'd0);
        chk("rst_wdata", 64'(mem_wdata_a), 64'd0);
        chk("rst_wc", 64'(word_count_a), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            wa_q.delete();
            wd_q.delete();
            d0 = done_cnt;
            do_start(tbl[k].base);
            send(tbl[k].cls, tbl[k].rs, tbl[k].rt, tbl[k].rd,
                 tbl[k].fn, tbl[k].imm, tbl[k].tg, 1'b1);
            wait_idle();
            chk($sformatf("v%0d_nwr", k), 64'(wa_q.size()), 64'(tbl[k].exp_we));
            if (tbl[k].exp_we && wa_q.size() > 0) begin
                chk($sformatf("v%0d_addr", k), 64'(wa_q[0]), 64'(tbl[k].base));
                chk($sformatf("v%0d_data", k), 64'(wd_q[0]), 64'(tbl[k].exp_d));
            end
            chk($sformatf("v%0d_err", k), 64'(s_err), 64'(tbl[k].exp_err));
            chk($sformatf("v%0d_wc", k), 64'(s_wc), 64'(tbl[k].exp_we));
            chk($sformatf("v%0d_done", k), 64'(done_cnt - d0), 64'd1);
        end

        wa_q.delete(); wd_q.delete();
        d0 = done_cnt;
        do_start(8'h10);
        send(3'd1, 5'd16, 5'd9, 5'd0,  6'h00, 16'h0004, 26'h0,  1'b0);
        send(3'd0, 5'd8,  5'd9, 5'd10, 6'h20, 16'h0000, 26'h0,  1'b0);
        send(3'd2, 5'd16, 5'd9, 5'd0,  6'h00, 16'h0008, 26'h0,  1'b0);
        send(3'd3, 5'd8,  5'd9, 5'd0,  6'h00, 16'hFFFE, 26'h0,  1'b0);
        send(3'd4, 5'd0,  5'd0, 5'd0,  6'h00, 16'h0000, 26'h10, 1'b1);
        wait_idle();
        chk("strm_nwr", 64'(wa_q.size()), 64'd5);
        if (wa_q.size() == 5) begin
            chk("strm_a0", 64'({wa_q[0], wd_q[0]}), {24'd0, 8'h10, 32'h8E090004});
            chk("strm_a1", 64'({wa_q[1], wd_q[1]}), {24'd0, 8'h11, 32'h01095020});
            chk("strm_a2", 64'({wa_q[2], wd_q[2]}), {24'd0, 8'h12, 32'hAE090008});
            chk("strm_a3", 64'({wa_q[3], wd_q[3]}), {24'd0, 8'h13, 32'h1109FFFE});
            chk("strm_a4", 64'({wa_q[4], wd_q[4]}), {24'd0, 8'h14, 32'h08000010});
        end
        chk("strm_wc", 64'(word_count_a), 64'd5);
        chk("strm_err", 64'(err_a), 64'd0);
        chk("strm_done", 64'(done_cnt - d0), 64'd1);

        wa_q.delete(); wd_q.delete();
        mem_ready = 1'b0;
        do_start(8'h20);
        send(3'd1, 5'd16, 5'd9, 5'd0, 6'h00, 16'h0004, 26'h0, 1'b0);
        in_cls = 3'd0; in_rs = 5'd8; in_rt = 5'd9; in_rd = 5'd10;
        in_funct = 6'h20; in_last = 1'b0; in_valid = 1'b1;
        #1;
        chk("stall1_rdy", 64'(in_ready_a), 64'd0);
        chk("stall1_we", 64'(mem_we_a), 64'd1);
        chk("stall1_aw", 64'({mem_addr_a, mem_wdata_a}), {24'd0, 8'h20, 32'h8E090004});
        @(negedge clk);
        #1;
        chk("stall2_rdy", 64'(in_ready_a), 64'd0);
        chk("stall2_aw", 64'({mem_we_a, mem_addr_a, mem_wdata_a}), {23'd0, 1'b1, 8'h20, 32'h8E090004});
        mem_ready = 1'b1;
        #1;
        chk("stall_rel_rdy", 64'(in_ready_a), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_b_aw", 64'({mem_we_a, mem_addr_a, mem_wdata_a}), {23'd0, 1'b1, 8'h21, 32'h01095020});
        chk("stall_b_wc", 64'(word_count_a), 64'd1);
        send(3'd2, 5'd16, 5'd9, 5'd0, 6'h00, 16'h0008, 26'h0, 1'b1);
        wait_idle();
        chk("stall_nwr", 64'(wa_q.size()), 64'd3);
        if (wa_q.size() == 3)
            chk("stall_c", 64'({wa_q[2], wd_q[2]}), {24'd0, 8'h22, 32'hAE090008});
        chk("stall_wc", 64'(word_count_a), 64'd3);

        wa_q.delete(); wd_q.delete();
        do_start(8'h40);
        send(3'd1, 5'd16, 5'd9, 5'd0, 6'h00, 16'h0004, 26'h0, 1'b0);
        send(3'd7, 5'd1,  5'd2, 5'd3, 6'h20, 16'h0001, 26'h1, 1'b0);
        send(3'd2, 5'd16, 5'd9, 5'd0, 6'h00, 16'h0008, 26'h0, 1'b1);
        wait_idle();
        chk("ill_nwr", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            chk("ill_w0", 64'({wa_q[0], wd_q[0]}), {24'd0, 8'h40, 32'h8E090004});
            chk("ill_w1", 64'({wa_q[1], wd_q[1]}), {24'd0, 8'h41, 32'hAE090008});
        end
        chk("ill_err", 64'(err_a), 64'd1);
        chk("ill_wc", 64'(word_count_a), 64'd2);
        repeat (2) @(negedge clk);
        chk("ill_err_sticky", 64'(err_a), 64'd1);
        do_start(8'h00);
        chk("ill_err_clr", 64'(err_a), 64'd0);
        send(3'd4, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h1, 1'b1);
        wait_idle();

        sel = 1'b1;
        wa_q.delete(); wd_q.delete();
        do_start(8'h03);
        for (int i = 1; i <= 5; i++)
            send(3'd4, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'(i), i == 5);
        wait_idle();
        chk("wrap_nwr", 64'(wa_q.size()), 64'd4);
        if (wa_q.size() == 4) begin
            chk("wrap_w0", 64'({wa_q[0], wd_q[0]}), {24'd0, 8'h03, 32'h08000001});
            chk("wrap_w1", 64'({wa_q[1], wd_q[1]}), {24'd0, 8'h00, 32'h08000002});
            chk("wrap_w2", 64'({wa_q[2], wd_q[2]}), {24'd0, 8'h01, 32'h08000003});
            chk("wrap_w3", 64'({wa_q[3], wd_q[3]}), {24'd0, 8'h02, 32'h08000004});
        end
        chk("wrap_err", 64'(err_b), 64'd1);
        chk("wrap_wc", 64'(word_count_b), 64'd4);
        sel = 1'b0;

        wa_q.delete(); wd_q.delete();
        mem_ready = 1'b0;
        do_start(8'h50);
        send(3'd1, 5'd16, 5'd9, 5'd0, 6'h00, 16'h0004, 26'h0, 1'b0);
        chk("rstm_pending", 64'(mem_we_a), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstm_we", 64'(mem_we_a), 64'd0);
        chk("rstm_busy", 64'(busy_a), 64'd0);
        chk("rstm_wc", 64'(word_count_a), 64'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rstm_nwr", 64'(wa_q.size()), 64'd0);
        do_start(8'h60);
        send(3'd4, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h10, 1'b1);
        wait_idle();
        chk("rstm_new_nwr", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1)
            chk("rstm_new_w", 64'({wa_q[0], wd_q[0]}), {24'd0, 8'h60, 32'h08000010});
        chk("rstm_new_wc", 64'(word_count_a), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
